vector_list_player: RTL and testbench
=====================================

VECTOR_LIST_PLAYER -- requirements
Module: vector_list_player

Interface
REQ-001 The block SHALL have parameter BITS, default 16, coordinate width, equal to the downstream line generator's coordinate width.
REQ-002 The block SHALL have parameter ADDR_BITS, default 10, display-list address width.
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, begin playing the list from address 0.
REQ-006 The block SHALL have port loop, input, 1, sampled at END entry: 1 = replay the frame, 0 = stop.
REQ-007 The block SHALL have port mem_addr, output, ADDR_BITS, display-list read address.
REQ-008 The block SHALL have port mem_rd, output, 1, read enable; mem_data is valid exactly one cycle after mem_rd is high.
REQ-009 The block SHALL have port mem_data, input, 2*BITS+2, list entry: [2*BITS+1:2*BITS] cmd, [2*BITS-1:BITS] x, [BITS-1:0] y.
REQ-010 The block SHALL have port line_ready, input, 1, line generator at destination, ready for a new point.
REQ-011 The block SHALL have port strobe, output, 1, one-cycle pulse loading x_out/y_out into the line generator.
REQ-012 The block SHALL have port x_out, output, BITS, destination X; held between strobes.
REQ-013 The block SHALL have port y_out, output, BITS, destination Y; held between strobes.
REQ-014 The block SHALL have port bright, output, 1, beam enable: 1 for a DRAW segment, 0 for a MOVE segment.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port frame_done, output, 1, one-cycle pulse when an END entry is processed.

Function
REQ-017 The block SHALL decode cmd as: 00 MOVE, 01 DRAW, 10 NOP, 11 END.
REQ-018 The block SHALL implement states IDLE, FETCH, LATCH, ISSUE; all outputs SHALL be registered.
REQ-019 The block SHALL transition IDLE->FETCH on start=1 and set the address pointer to 0.
REQ-020 The block SHALL, in FETCH, drive mem_rd=1 and mem_addr=pointer for exactly one cycle, then go to LATCH.
REQ-021 The block SHALL, in LATCH, capture mem_data and increment the pointer (modulo 2^ADDR_BITS, wrapping to 0 without any other effect).
REQ-022 The block SHALL, on a LATCH decode of NOP, go to FETCH with no output change.
REQ-023 The block SHALL, on a LATCH decode of MOVE/DRAW, go to ISSUE.
REQ-024 The block SHALL, on a LATCH decode of END, pulse frame_done for one cycle; if loop=1, it SHALL reset the pointer to 0 and go to FETCH; otherwise it SHALL go to IDLE.
REQ-025 The block SHALL, in ISSUE, wait while line_ready=0; in the first cycle line_ready=1 it SHALL assert strobe for one cycle, load x_out, y_out, and bright (DRAW=1, MOVE=0) in that same cycle, then go to FETCH.
REQ-026 The block SHALL never assert strobe in two consecutive cycles; the minimum spacing between strobes SHALL be 3 cycles (ISSUE, FETCH, LATCH).
REQ-027 The block SHALL give a latency of 3 cycles from start sampled high to the first strobe when line_ready=1: FETCH at k+1, LATCH at k+2, strobe at k+3.
REQ-028 The block SHALL ignore start while busy=1.
REQ-029 The block SHALL hold bright at its last value until the next strobe; bright SHALL be forced to 0 on entry to IDLE.
REQ-030 The block SHALL never change x_out/y_out except in the strobe cycle.

Reset
REQ-031 The block SHALL, on reset, set state=IDLE, pointer=0, mem_addr=0, mem_rd=0, strobe=0, x_out=0, y_out=0, bright=0, busy=0, frame_done=0.
REQ-032 The block SHALL give reset priority over start and all other inputs; reset mid-frame SHALL abort in the next cycle with no further strobe or mem_rd.

Verification
REQ-033 Verification SHALL cover: list {DRAW(100,200), END}, loop=0, line_ready=1 -> strobe at start+3 with x_out=100, y_out=200, bright=1; frame_done 2 cycles later; then IDLE, busy=0.
REQ-034 Verification SHALL cover: {MOVE(10,10), DRAW(50,10), END}, with line_ready held low 20 cycles after each strobe -> strobes spaced by at least 20 cycles, bright sequence 0 then 1, no strobe while line_ready=0.
REQ-035 Verification SHALL cover: {NOP, NOP, DRAW(7,9), END} -> first strobe at start+7 with x_out=7, y_out=9, and mem_addr sequence 0,1,2,3.
REQ-036 Verification SHALL cover: {DRAW(1,1), END}, loop=1 -> frame_done repeats; strobes with (1,1) recur indefinitely; mem_addr returns to 0 after each END.
REQ-037 Verification SHALL cover: ADDR_BITS=2 with no END in the list -> pointer wraps 3->0 and playback continues.
REQ-038 Verification SHALL cover: reset asserted in ISSUE while waiting, and start pulsed while busy -> no strobe after reset and all outputs at reset values; start while busy ignored.

Source files
------------

// File: rtl/vector_list_player.sv
// Vector display-list player: walks a list of MOVE/DRAW/NOP/END entries from
// memory and hands each MOVE/DRAW endpoint to a line generator, one point at a
// time, using line_ready as back-pressure.
module vector_list_player #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 loop,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [2*BITS+1:0]    mem_data,
    input  logic                 line_ready,
    output logic                 strobe,
    output logic [BITS-1:0]      x_out,
    output logic [BITS-1:0]      y_out,
    output logic                 bright,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [1:0] CMD_MOVE = 2'b00;
    localparam logic [1:0] CMD_DRAW = 2'b01;
    localparam logic [1:0] CMD_NOP  = 2'b10;
    localparam logic [1:0] CMD_END  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_LATCH = 2'b10,
        ST_ISSUE = 2'b11
    } state_e;

    state_e               state_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic [ADDR_BITS-1:0] ptr_d;
    logic [BITS-1:0]      ent_x_q;
    logic [BITS-1:0]      ent_y_q;
    logic                 ent_draw_q;

    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 mem_rd_q;
    logic                 strobe_q;
    logic [BITS-1:0]      x_out_q;
    logic [BITS-1:0]      y_out_q;
    logic                 bright_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic [1:0]           cmd_w;
    logic [BITS-1:0]      x_w;
    logic [BITS-1:0]      y_w;

    // Entry field split and the wrapping pointer increment.
    assign cmd_w = mem_data[2*BITS+1:2*BITS];
    assign x_w   = mem_data[2*BITS-1:BITS];
    assign y_w   = mem_data[BITS-1:0];
    assign ptr_d = ptr_q + ADDR_BITS'(1);

    // Player state machine; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            ent_x_q      <= '0;
            ent_y_q      <= '0;
            ent_draw_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            strobe_q     <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            bright_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-asserted below.
            mem_rd_q     <= 1'b0;
            strobe_q     <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q      <= '0;
                        mem_addr_q <= '0;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end

                // Read request is on the bus this cycle; data arrives next cycle.
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                end

                ST_LATCH: begin
                    ptr_q      <= ptr_d;
                    ent_x_q    <= x_w;
                    ent_y_q    <= y_w;
                    ent_draw_q <= (cmd_w == CMD_DRAW);
                    case (cmd_w)
                        CMD_NOP: begin
                            mem_addr_q <= ptr_d;
                            mem_rd_q   <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                        CMD_END: begin
                            frame_done_q <= 1'b1;
                            if (loop) begin
                                ptr_q      <= '0;
                                mem_addr_q <= '0;
                                mem_rd_q   <= 1'b1;
                                state_q    <= ST_FETCH;
                            end else begin
                                bright_q <= 1'b0;
                                busy_q   <= 1'b0;
                                state_q  <= ST_IDLE;
                            end
                        end
                        CMD_MOVE, CMD_DRAW: begin
                            state_q <= ST_ISSUE;
                        end
                        default: begin
                            state_q <= ST_ISSUE;
                        end
                    endcase
                end

                // Hold the point until the line generator can take it, then
                // start fetching the following entry in the same cycle.
                ST_ISSUE: begin
                    if (line_ready) begin
                        strobe_q   <= 1'b1;
                        x_out_q    <= ent_x_q;
                        y_out_q    <= ent_y_q;
                        bright_q   <= ent_draw_q;
                        mem_addr_q <= ptr_q;
                        mem_rd_q   <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign strobe     = strobe_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign bright     = bright_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vector_list_player.sv
// Bench for vector_list_player: a list-walking reference model predicts the
// full per-cycle output trace, which is compared against the DUT.
`timescale 1ns/1ps
module tb_vector_list_player;

    localparam int unsigned BITS = 16;
    localparam int unsigned AW   = 10;
    localparam int unsigned AWB  = 2;
    localparam int unsigned EW   = 2*BITS+2;
    localparam int          H    = 160;

    localparam logic [1:0] C_MOVE = 2'b00;
    localparam logic [1:0] C_DRAW = 2'b01;
    localparam logic [1:0] C_NOP  = 2'b10;
    localparam logic [1:0] C_END  = 2'b11;

    typedef struct packed {
        logic            busy;
        logic            rd;
        logic [AW-1:0]   addr;
        logic            stb;
        logic [BITS-1:0] x;
        logic [BITS-1:0] y;
        logic            bright;
        logic            fd;
    } trace_t;

    logic clk = 1'b0;
    logic reset, start, loop, line_ready;

    logic [AW-1:0]   addr_a;
    logic            rd_a, stb_a, bright_a, busy_a, fd_a;
    logic [EW-1:0]   data_a;
    logic [BITS-1:0] x_a, y_a;

    logic [AWB-1:0]  addr_b;
    logic            rd_b, stb_b, bright_b, busy_b, fd_b;
    logic [EW-1:0]   data_b;
    logic [BITS-1:0] x_b, y_b;

    logic [EW-1:0] mem_a [1024];
    logic [EW-1:0] mem_b [4];

    trace_t exp_t [H];
    trace_t act_t [H];
    bit     ready_rel [H];
    bit     start_rel [H];
    int     idle_at;
    bit     sel;
    int     n_cmp, n_mis;

    vector_list_player #(.BITS(BITS), .ADDR_BITS(AW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .loop(loop),
        .mem_addr(addr_a), .mem_rd(rd_a), .mem_data(data_a),
        .line_ready(line_ready), .strobe(stb_a), .x_out(x_a), .y_out(y_a),
        .bright(bright_a), .busy(busy_a), .frame_done(fd_a)
    );

    vector_list_player #(.BITS(BITS), .ADDR_BITS(AWB)) dut_b (
        .clk(clk), .reset(reset), .start(start), .loop(loop),
        .mem_addr(addr_b), .mem_rd(rd_b), .mem_data(data_b),
        .line_ready(line_ready), .strobe(stb_b), .x_out(x_b), .y_out(y_b),
        .bright(bright_b), .busy(busy_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    // One-cycle read latency memories; garbage on the bus when not reading.
    always @(posedge clk) begin
        data_a <= rd_a ? mem_a[addr_a] : EW'({$urandom(), $urandom()});
        data_b <= rd_b ? mem_b[addr_b] : EW'({$urandom(), $urandom()});
    end

    function automatic logic [EW-1:0] mk(input logic [1:0] c, input logic [BITS-1:0] x,
                                         input logic [BITS-1:0] y);
        return {c, x, y};
    endfunction

    function automatic trace_t snap();
        trace_t t;
        t.busy   = sel ? busy_b : busy_a;
        t.rd     = sel ? rd_b : rd_a;
        t.addr   = sel ? AW'(addr_b) : addr_a;
        if (!t.rd) t.addr = '0;
        t.stb    = sel ? stb_b : stb_a;
        t.x      = sel ? x_b : x_a;
        t.y      = sel ? y_b : y_a;
        t.bright = sel ? bright_b : bright_a;
        t.fd     = sel ? fd_b : fd_a;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; line_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem_a[i] = mk(C_END, '0, '0);
        for (int i = 0; i < 4; i++) mem_b[i] = mk(C_END, '0, '0);
    endtask

    task automatic fill_ready(input int pct);
        for (int r = 0; r < H; r++) ready_rel[r] = ($urandom_range(0, 99) < pct);
    endtask

    // Walk the list entry by entry, placing each event at the cycle where the
    // player's timing rules put it (relative to the edge that samples start).
    task automatic build_model(input bit lp, input bit post_low);
        int c, p, d, e, asz;
        bit done;
        logic [EW-1:0] ent;
        logic [1:0] cmd;
        logic [BITS-1:0] hx, hy;
        logic hb;
        asz = sel ? 4 : 1024;
        for (int r = 0; r < H; r++) exp_t[r] = '0;
        c = 0; p = 0; done = 1'b0; idle_at = H;
        while (!done && c < H) begin
            exp_t[c].rd   = 1'b1;
            exp_t[c].addr = AW'(p);
            ent = sel ? mem_b[p[1:0]] : mem_a[p[9:0]];
            cmd = ent[EW-1:EW-2];
            p = (p + 1) % asz;
            d = c + 2;
            if (cmd == C_NOP) begin
                c = d;
            end else if (cmd == C_END) begin
                if (d < H) exp_t[d].fd = 1'b1;
                if (lp) begin
                    p = 0; c = d;
                end else begin
                    idle_at = d; done = 1'b1;
                end
            end else begin
                e = c + 3;
                while (e < H && !ready_rel[e-1]) e++;
                if (e >= H) begin
                    done = 1'b1;
                end else begin
                    exp_t[e].stb    = 1'b1;
                    exp_t[e].x      = ent[2*BITS-1:BITS];
                    exp_t[e].y      = ent[BITS-1:0];
                    exp_t[e].bright = (cmd == C_DRAW);
                    if (post_low)
                        for (int j = e; j < e + 20 && j < H; j++) ready_rel[j] = 1'b0;
                    c = e;
                end
            end
        end
        hx = '0; hy = '0; hb = 1'b0;
        for (int r = 0; r < H; r++) begin
            if (exp_t[r].stb) begin
                hx = exp_t[r].x; hy = exp_t[r].y; hb = exp_t[r].bright;
            end
            if (r >= idle_at) hb = 1'b0;
            exp_t[r].x      = hx;
            exp_t[r].y      = hy;
            exp_t[r].bright = hb;
            exp_t[r].busy   = (r < idle_at);
        end
    endtask

    // Extra start pulses only where the player is predicted to be busy.
    task automatic gen_starts(input bit en);
        for (int r = 0; r < H; r++)
            start_rel[r] = en && exp_t[r].busy && ($urandom_range(0, 15) == 0);
    endtask

    task automatic play(input bit lp);
        @(negedge clk);
        start = 1'b1; loop = lp; line_ready = 1'b0;
        @(posedge clk);
        for (int r = 0; r < H; r++) begin
            @(negedge clk);
            act_t[r]   = snap();
            start      = start_rel[r];
            line_ready = ready_rel[r];
        end
        start = 1'b0; line_ready = 1'b0;
    endtask

    task automatic test_reset();
        trace_t t;
        do_reset();
        sel = 1'b0; t = snap();
        n_cmp++; if (t !== trace_t'('0)) begin n_mis++; $display("FAIL reset_a got %h expected 0", t); end
        n_cmp++; if (addr_a !== '0) begin n_mis++; $display("FAIL reset_addr got %h expected 0", addr_a); end
        sel = 1'b1; t = snap();
        n_cmp++; if (t !== trace_t'('0)) begin n_mis++; $display("FAIL reset_b got %h expected 0", t); end
        sel = 1'b0;
        @(negedge clk); t = snap();
        n_cmp++; if (t !== trace_t'('0)) begin n_mis++; $display("FAIL reset_idle got %h expected 0", t); end
    endtask

    task automatic test_single_draw();
        do_reset(); clear_mem(); sel = 1'b0;
        mem_a[0] = mk(C_DRAW, 16'd100, 16'd200);
        mem_a[1] = mk(C_END, 16'd0, 16'd0);
        fill_ready(100); build_model(1'b0, 1'b0); gen_starts(1'b1); play(1'b0);
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (act_t[r] !== exp_t[r]) begin n_mis++; $display("FAIL single_draw cyc %0d got %h expected %h", r, act_t[r], exp_t[r]); end
        end
        n_cmp++;
        if (!(act_t[3].stb === 1'b1 && act_t[3].x === 16'd100 && act_t[3].y === 16'd200 && act_t[3].bright === 1'b1)) begin
            n_mis++; $display("FAIL single_draw_strobe got stb=%b x=%0d y=%0d b=%b expected 1/100/200/1",
                              act_t[3].stb, act_t[3].x, act_t[3].y, act_t[3].bright);
        end
        n_cmp++;
        if (!(act_t[5].fd === 1'b1 && act_t[5].busy === 1'b0 && act_t[6].busy === 1'b0 && act_t[5].bright === 1'b0)) begin
            n_mis++; $display("FAIL single_draw_done got fd=%b busy=%b bright=%b expected 1/0/0",
                              act_t[5].fd, act_t[5].busy, act_t[5].bright);
        end
    endtask

    task automatic test_backpressure();
        int ns, s0, s1;
        logic b0, b1;
        do_reset(); clear_mem(); sel = 1'b0;
        mem_a[0] = mk(C_MOVE, 16'd10, 16'd10);
        mem_a[1] = mk(C_DRAW, 16'd50, 16'd10);
        mem_a[2] = mk(C_END, 16'd0, 16'd0);
        fill_ready(100); build_model(1'b0, 1'b1); gen_starts(1'b1); play(1'b0);
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (act_t[r] !== exp_t[r]) begin n_mis++; $display("FAIL backpressure cyc %0d got %h expected %h", r, act_t[r], exp_t[r]); end
        end
        ns = 0; s0 = 0; s1 = 0; b0 = 1'b0; b1 = 1'b0;
        for (int r = 1; r < H; r++) begin
            if (act_t[r].stb === 1'b1) begin
                n_cmp++;
                if (ready_rel[r-1] !== 1'b1) begin n_mis++; $display("FAIL strobe_while_not_ready cyc %0d got ready=0 expected 1", r); end
                if (ns == 0) begin s0 = r; b0 = act_t[r].bright; end
                else if (ns == 1) begin s1 = r; b1 = act_t[r].bright; end
                ns++;
            end
        end
        n_cmp++;
        if (!(ns == 2 && s1 - s0 >= 20 && b0 === 1'b0 && b1 === 1'b1)) begin
            n_mis++; $display("FAIL backpressure_seq got n=%0d gap=%0d bright=%b%b expected n=2 gap>=20 bright=01",
                              ns, s1 - s0, b0, b1);
        end
    endtask

    task automatic test_nop_skip();
        int na;
        logic [AW-1:0] addrs [4];
        do_reset(); clear_mem(); sel = 1'b0;
        mem_a[0] = mk(C_NOP, 16'd0, 16'd0);
        mem_a[1] = mk(C_NOP, 16'd0, 16'd0);
        mem_a[2] = mk(C_DRAW, 16'd7, 16'd9);
        mem_a[3] = mk(C_END, 16'd0, 16'd0);
        fill_ready(100); build_model(1'b0, 1'b0); gen_starts(1'b0); play(1'b0);
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (act_t[r] !== exp_t[r]) begin n_mis++; $display("FAIL nop_skip cyc %0d got %h expected %h", r, act_t[r], exp_t[r]); end
        end
        n_cmp++;
        if (!(act_t[7].stb === 1'b1 && act_t[7].x === 16'd7 && act_t[7].y === 16'd9)) begin
            n_mis++; $display("FAIL nop_first_strobe got stb=%b x=%0d y=%0d expected 1/7/9", act_t[7].stb, act_t[7].x, act_t[7].y);
        end
        na = 0;
        for (int r = 0; r < H; r++) begin
            if (act_t[r].rd === 1'b1) begin
                if (na < 4) addrs[na] = act_t[r].addr;
                na++;
            end
        end
        n_cmp++;
        if (!(na == 4 && addrs[0] === 10'd0 && addrs[1] === 10'd1 && addrs[2] === 10'd2 && addrs[3] === 10'd3)) begin
            n_mis++; $display("FAIL nop_addr_seq got n=%0d first=%0d,%0d,%0d,%0d expected 4 reads 0,1,2,3",
                              na, addrs[0], addrs[1], addrs[2], addrs[3]);
        end
    endtask

    task automatic test_loop();
        int nfd, nstb;
        do_reset(); clear_mem(); sel = 1'b0;
        mem_a[0] = mk(C_DRAW, 16'd1, 16'd1);
        mem_a[1] = mk(C_END, 16'd0, 16'd0);
        fill_ready(100); build_model(1'b1, 1'b0); gen_starts(1'b1); play(1'b1);
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (act_t[r] !== exp_t[r]) begin n_mis++; $display("FAIL loop cyc %0d got %h expected %h", r, act_t[r], exp_t[r]); end
        end
        nfd = 0; nstb = 0;
        for (int r = 0; r < H; r++) begin
            if (act_t[r].fd === 1'b1) begin
                nfd++;
                n_cmp++;
                if (!(act_t[r].rd === 1'b1 && act_t[r].addr === 10'd0)) begin
                    n_mis++; $display("FAIL loop_restart cyc %0d got rd=%b addr=%0d expected rd=1 addr=0", r, act_t[r].rd, act_t[r].addr);
                end
            end
            if (act_t[r].stb === 1'b1 && act_t[r].x === 16'd1 && act_t[r].y === 16'd1) nstb++;
        end
        n_cmp++;
        if (nfd < 20 || nstb < 20) begin
            n_mis++; $display("FAIL loop_repeat got frames=%0d strobes=%0d expected >=20 each", nfd, nstb);
        end
    endtask

    task automatic test_wrap();
        int n0;
        do_reset(); clear_mem(); sel = 1'b1;
        mem_b[0] = mk(C_MOVE, BITS'($urandom()), BITS'($urandom()));
        mem_b[1] = mk(C_DRAW, BITS'($urandom()), BITS'($urandom()));
        mem_b[2] = mk(C_NOP, '0, '0);
        mem_b[3] = mk(C_DRAW, BITS'($urandom()), BITS'($urandom()));
        fill_ready(75); build_model(1'b0, 1'b0); gen_starts(1'b1); play(1'b0);
        for (int r = 0; r < H; r++) begin
            n_cmp++;
            if (act_t[r] !== exp_t[r]) begin n_mis++; $display("FAIL wrap cyc %0d got %h expected %h", r, act_t[r], exp_t[r]); end
        end
        n0 = 0;
        for (int r = 0; r < H; r++) if (act_t[r].rd === 1'b1 && act_t[r].addr === 10'd0) n0++;
        n_cmp++;
        if (n0 < 2) begin n_mis++; $display("FAIL wrap_addr0 got %0d reads of addr 0 expected >=2", n0); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        int len;
        bit lp;
        for (int it = 0; it < 6; it++) begin
            do_reset(); clear_mem(); sel = 1'b0;
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++)
                mem_a[i] = mk(2'($urandom_range(0, 2)), BITS'($urandom()), BITS'($urandom()));
            mem_a[len] = mk(C_END, '0, '0);
            lp = 1'($urandom_range(0, 1));
            fill_ready($urandom_range(30, 100));
            build_model(lp, 1'b0); gen_starts(1'b1); play(lp);
            for (int r = 0; r < H; r++) begin
                n_cmp++;
                if (act_t[r] !== exp_t[r]) begin n_mis++; $display("FAIL random%0d cyc %0d got %h expected %h", it, r, act_t[r], exp_t[r]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nrd, nstb;
        trace_t t;
        do_reset(); clear_mem(); sel = 1'b0;
        mem_a[0] = mk(C_DRAW, 16'd300, 16'd400);
        mem_a[1] = mk(C_END, 16'd0, 16'd0);
        @(negedge clk); start = 1'b1; loop = 1'b0; line_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        t = snap(); nrd = t.rd ? 1 : 0; nstb = t.stb ? 1 : 0;
        for (int r = 1; r < 8; r++) begin
            @(negedge clk);
            start = (r == 3);
            t = snap();
            if (t.rd) nrd++;
            if (t.stb) nstb++;
        end
        n_cmp++;
        if (!(nrd == 1 && nstb == 0 && t.busy === 1'b1)) begin
            n_mis++; $display("FAIL busy_start got reads=%0d strobes=%0d busy=%b expected 1/0/1", nrd, nstb, t.busy);
        end
        reset = 1'b1; line_ready = 1'b1;
        @(negedge clk);
        t = snap();
        n_cmp++; if (t !== trace_t'('0)) begin n_mis++; $display("FAIL reset_mid got %h expected 0", t); end
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            t = snap();
            n_cmp++;
            if (t !== trace_t'('0) || addr_a !== '0) begin
                n_mis++; $display("FAIL reset_mid_after cyc %0d got %h addr=%0d expected 0", r, t, addr_a);
            end
        end
        line_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0;
        reset = 1'b1; start = 1'b0; loop = 1'b0; line_ready = 1'b0; sel = 1'b0;
        test_reset();
        test_single_draw();
        test_backpressure();
        test_nop_skip();
        test_loop();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
